// File: rtl/mac_n_bit_pipelined_pkg.sv
// Shared sizing helpers and constants for the pipelined multiply-accumulate unit.
// Latency: n/a (compile-time functions only).
// Backpressure: n/a.
package mac_n_bit_pipelined_pkg;

    // Full-width product of an n-bit by m-bit multiply.
    function automatic int prod_width(input int n, input int m);
        return n + m;
    endfunction

    // Rows handled by every row group except possibly the last.
    function automatic int rows_per_stage(input int rows, input int stages);
        return (rows + stages - 1) / stages;
    endfunction

    // First row of group g; clamped so trailing groups may be empty.
    function automatic int group_lo(input int rows, input int stages, input int g);
        int lo;
        lo = g * rows_per_stage(rows, stages);
        return (lo > rows) ? rows : lo;
    endfunction

    // One past the last row of group g.
    function automatic int group_hi(input int rows, input int stages, input int g);
        int hi;
        hi = (g + 1) * rows_per_stage(rows, stages);
        return (hi > rows) ? rows : hi;
    endfunction

    // Baugh-Wooley correction: 2^(n-1) + 2^(m-1) + 2^(n+m-1), taken modulo the
    // product width by the caller. Added, not OR-ed, because n may equal m.
    function automatic logic [63:0] bw_correction(input int n, input int m);
        return (64'h1 << (n - 1)) + (64'h1 << (m - 1)) + (64'h1 << (n + m - 1));
    endfunction

    // Saturation limits for a w-bit accumulator; caller truncates to w bits.
    function automatic logic [63:0] sat_max(input int w, input logic is_signed);
        return is_signed ? (64'hFFFF_FFFF_FFFF_FFFF >> (65 - w))
                         : (64'hFFFF_FFFF_FFFF_FFFF >> (64 - w));
    endfunction

    function automatic logic [63:0] sat_min(input int w, input logic is_signed);
        return is_signed ? (64'h1 << (w - 1)) : 64'h0;
    endfunction

endpackage

// File: rtl/look_ahead_adder_n_bit.sv
// WIDTH-bit adder built from generate/propagate terms; carry-out is dropped,
// callers widen the operands by one bit when they need it.
// Latency: combinational. Backpressure: none.
// Ports: a, b addends; sum result modulo 2^WIDTH.
module look_ahead_adder_n_bit #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum
);
    logic [WIDTH-1:0] gen;
    logic [WIDTH-1:0] prop;
    logic             carry;

    assign gen  = a & b;
    assign prop = a ^ b;

    always_comb begin
        carry = 1'b0;
        sum   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            sum[i] = prop[i] ^ carry;
            carry  = gen[i] | (prop[i] & carry);
        end
    end
endmodule

// File: rtl/mac_row_group.sv
// Adds partial-product rows LO..LO+ROWS-1 into a carried partial sum, with
// Baugh-Wooley inversion of the sign-row / sign-column cross terms.
// Latency: combinational. Backpressure: none.
// Ports: a full multiplier; b_rows the multiplicand bits for this group's rows;
//        signed_mode; sum_in carried partial sum; sum_out updated partial sum.
module mac_row_group #(
    parameter int N    = 4,
    parameter int M    = 4,
    parameter int P    = 8,
    parameter int LO   = 0,
    parameter int ROWS = 1
) (
    input  logic [N-1:0]    a,
    input  logic [ROWS-1:0] b_rows,
    input  logic            signed_mode,
    input  logic [P-1:0]    sum_in,
    output logic [P-1:0]    sum_out
);
    logic [P-1:0] chain [ROWS+1];

    assign chain[0] = sum_in;

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        localparam int J = LO + r;
        logic [N-1:0] and_bits;
        logic [N-1:0] row_bits;
        logic [P-1:0] row_vec;

        for (genvar i = 0; i < N; i++) begin : g_bit
            // Exactly one of the two operand sign bits takes part in this term.
            localparam bit CROSS = (i == N - 1) != (J == M - 1);
            single_bit_multiply u_pp (
                .a (a[i]),
                .b (b_rows[r]),
                .p (and_bits[i])
            );
            assign row_bits[i] = and_bits[i] ^ (signed_mode & CROSS);
        end

        assign row_vec = P'(row_bits) << J;

        look_ahead_adder_n_bit #(.WIDTH(P)) u_add (
            .a   (chain[r]),
            .b   (row_vec),
            .sum (chain[r+1])
        );
    end

    assign sum_out = chain[ROWS];
endmodule

// File: rtl/single_bit_multiply.sv
// One partial-product bit: a AND b.
// Latency: combinational.
// Backpressure: none.
// Ports: a, b operand bits; p product bit.
module single_bit_multiply (
    input  logic a,
    input  logic b,
    output logic p
);
    assign p = a & b;
endmodule

// File: rtl/mac_n_bit_pipelined.sv
// Pipelined multiply-accumulate: signed (Baugh-Wooley) or unsigned product per op,
// folded into a wide accumulator with optional saturation and sticky overflow.
// Latency: STAGES+1 cycles load -> load_out. Backpressure: none, one op per cycle.
// Ports: clk, reset (sync, active-high); multiplier, multiplicand, signed_mode,
//        acc_clear, load in; product, accumulator, overflow, load_out out.
module mac_n_bit_pipelined
    import mac_n_bit_pipelined_pkg::*;
#(
    parameter int MULTIPLIER_SIZE   = 4,
    parameter int MULTIPLICAND_SIZE = 4,
    parameter int STAGES            = 2,
    parameter int ACC_SIZE          = 16,
    parameter int SATURATE          = 1
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic [MULTIPLIER_SIZE-1:0]                 multiplier,
    input  logic [MULTIPLICAND_SIZE-1:0]               multiplicand,
    input  logic                                       signed_mode,
    input  logic                                       acc_clear,
    input  logic                                       load,
    output logic [MULTIPLIER_SIZE+MULTIPLICAND_SIZE-1:0] product,
    output logic [ACC_SIZE-1:0]                        accumulator,
    output logic                                       overflow,
    output logic                                       load_out
);
    localparam int N = MULTIPLIER_SIZE;
    localparam int M = MULTIPLICAND_SIZE;
    localparam int P = prod_width(N, M);

    localparam logic [P-1:0]        BW_CORR = P'(bw_correction(N, M));
    localparam logic [ACC_SIZE-1:0] U_MAX   = ACC_SIZE'(sat_max(ACC_SIZE, 1'b0));
    localparam logic [ACC_SIZE-1:0] S_MAX   = ACC_SIZE'(sat_max(ACC_SIZE, 1'b1));
    localparam logic [ACC_SIZE-1:0] S_MIN   = ACC_SIZE'(sat_min(ACC_SIZE, 1'b1));

    // Index 0 is the input register; index k+1 is the register after group k.
    // Operands are only needed up to the last group, hence STAGES entries.
    logic [N-1:0] a_q   [STAGES];
    logic [M-1:0] b_q   [STAGES];
    logic         sm_q  [STAGES+1];
    logic         clr_q [STAGES+1];
    logic         vld_q [STAGES+1];
    logic [P-1:0] sum_q [STAGES];

    logic [P-1:0] grp_in  [STAGES];
    logic [P-1:0] grp_out [STAGES];

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        localparam int LO = group_lo(M, STAGES, s);
        localparam int HI = group_hi(M, STAGES, s);

        // The correction constant seeds the very first partial sum in signed mode.
        if (s == 0) begin : g_first
            assign grp_in[s] = sm_q[0] ? BW_CORR : '0;
        end else begin : g_next
            assign grp_in[s] = sum_q[s-1];
        end

        // Trailing groups can be empty when rows don't divide evenly; they
        // still cost a register stage so latency stays STAGES+1.
        if (HI > LO) begin : g_rows
            mac_row_group #(
                .N    (N),
                .M    (M),
                .P    (P),
                .LO   (LO),
                .ROWS (HI - LO)
            ) u_row_group (
                .a           (a_q[s]),
                .b_rows      (b_q[s][HI-1:LO]),
                .signed_mode (sm_q[s]),
                .sum_in      (grp_in[s]),
                .sum_out     (grp_out[s])
            );
        end else begin : g_empty
            assign grp_out[s] = grp_in[s];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k <= STAGES; k++) begin
                vld_q[k] <= 1'b0;
            end
        end else begin
            vld_q[0] <= load;
            for (int k = 0; k < STAGES; k++) begin
                vld_q[k+1] <= vld_q[k];
            end
        end

        // Operands and their mode bits hold while load is low.
        if (load) begin
            a_q[0]   <= multiplier;
            b_q[0]   <= multiplicand;
            sm_q[0]  <= signed_mode;
            clr_q[0] <= acc_clear;
        end

        for (int k = 0; k < STAGES; k++) begin
            sum_q[k]   <= grp_out[k];
            sm_q[k+1]  <= sm_q[k];
            clr_q[k+1] <= clr_q[k];
        end
        for (int k = 0; k < STAGES - 1; k++) begin
            a_q[k+1] <= a_q[k];
            b_q[k+1] <= b_q[k];
        end
    end

    // Final stage: accumulate.
    logic [P-1:0]          result;
    logic                  fin_sm;
    logic                  fin_clr;
    logic [ACC_SIZE-1:0]   ext;
    logic [ACC_SIZE-1:0]   base;
    logic [ACC_SIZE:0]     acc_sum;
    logic                  add_ovf;
    logic [ACC_SIZE-1:0]   sat_val;
    logic [ACC_SIZE-1:0]   acc_next;

    assign result  = sum_q[STAGES-1];
    assign fin_sm  = sm_q[STAGES];
    assign fin_clr = clr_q[STAGES];
    assign ext     = fin_sm ? ACC_SIZE'($signed(result)) : ACC_SIZE'(result);
    assign base    = fin_clr ? '0 : accumulator;

    // One extra bit so the unsigned carry-out is visible.
    look_ahead_adder_n_bit #(.WIDTH(ACC_SIZE + 1)) u_acc_add (
        .a   ({1'b0, base}),
        .b   ({1'b0, ext}),
        .sum (acc_sum)
    );

    always_comb begin
        add_ovf  = 1'b0;
        sat_val  = U_MAX;
        acc_next = acc_sum[ACC_SIZE-1:0];
        if (fin_sm) begin
            // Signed overflow: like-signed addends producing a differently signed sum.
            add_ovf = (base[ACC_SIZE-1] == ext[ACC_SIZE-1]) &&
                      (acc_sum[ACC_SIZE-1] != base[ACC_SIZE-1]);
            sat_val = base[ACC_SIZE-1] ? S_MIN : S_MAX;
        end else begin
            add_ovf = acc_sum[ACC_SIZE];
        end
        if (add_ovf && (SATURATE != 0)) begin
            acc_next = sat_val;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            product     <= '0;
            accumulator <= '0;
            overflow    <= 1'b0;
            load_out    <= 1'b0;
        end else begin
            load_out <= vld_q[STAGES];
            if (vld_q[STAGES]) begin
                product     <= result;
                accumulator <= acc_next;
                overflow    <= (fin_clr ? 1'b0 : overflow) | add_ovf;
            end
        end
    end

endmodule

// File: tb/tb_mac_n_bit_pipelined.sv
// Bench for mac_n_bit_pipelined: five instances with different STAGES/ACC_SIZE/
// SATURATE share one stimulus stream, each checked every cycle against an
// arithmetic reference model driven by a history of accepted loads.
module tb_mac_n_bit_pipelined;

    logic       clk;
    logic       reset;
    logic [3:0] multiplier;
    logic [3:0] multiplicand;
    logic       signed_mode;
    logic       acc_clear;
    logic       load;

    logic [7:0]  prod_o [5];
    logic [15:0] acc_o  [3];
    logic [7:0]  acc8_o [2];
    logic        ovf_o  [5];
    logic        lo_o   [5];

    // Configurations: latency (STAGES+1), accumulator width, saturate.
    int cfg_lat [5] = '{3, 2, 4, 3, 3};
    int cfg_w   [5] = '{16, 16, 16, 8, 8};
    bit cfg_sat [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    mac_n_bit_pipelined #(.MULTIPLIER_SIZE(4), .MULTIPLICAND_SIZE(4), .STAGES(2),
                          .ACC_SIZE(16), .SATURATE(1)) dut0 (
        .clk(clk), .reset(reset), .multiplier(multiplier), .multiplicand(multiplicand),
        .signed_mode(signed_mode), .acc_clear(acc_clear), .load(load),
        .product(prod_o[0]), .accumulator(acc_o[0]), .overflow(ovf_o[0]), .load_out(lo_o[0]));

    mac_n_bit_pipelined #(.MULTIPLIER_SIZE(4), .MULTIPLICAND_SIZE(4), .STAGES(1),
                          .ACC_SIZE(16), .SATURATE(1)) dut1 (
        .clk(clk), .reset(reset), .multiplier(multiplier), .multiplicand(multiplicand),
        .signed_mode(signed_mode), .acc_clear(acc_clear), .load(load),
        .product(prod_o[1]), .accumulator(acc_o[1]), .overflow(ovf_o[1]), .load_out(lo_o[1]));

    mac_n_bit_pipelined #(.MULTIPLIER_SIZE(4), .MULTIPLICAND_SIZE(4), .STAGES(3),
                          .ACC_SIZE(16), .SATURATE(1)) dut2 (
        .clk(clk), .reset(reset), .multiplier(multiplier), .multiplicand(multiplicand),
        .signed_mode(signed_mode), .acc_clear(acc_clear), .load(load),
        .product(prod_o[2]), .accumulator(acc_o[2]), .overflow(ovf_o[2]), .load_out(lo_o[2]));

    mac_n_bit_pipelined #(.MULTIPLIER_SIZE(4), .MULTIPLICAND_SIZE(4), .STAGES(2),
                          .ACC_SIZE(8), .SATURATE(1)) dut3 (
        .clk(clk), .reset(reset), .multiplier(multiplier), .multiplicand(multiplicand),
        .signed_mode(signed_mode), .acc_clear(acc_clear), .load(load),
        .product(prod_o[3]), .accumulator(acc8_o[0]), .overflow(ovf_o[3]), .load_out(lo_o[3]));

    mac_n_bit_pipelined #(.MULTIPLIER_SIZE(4), .MULTIPLICAND_SIZE(4), .STAGES(2),
                          .ACC_SIZE(8), .SATURATE(0)) dut4 (
        .clk(clk), .reset(reset), .multiplier(multiplier), .multiplicand(multiplicand),
        .signed_mode(signed_mode), .acc_clear(acc_clear), .load(load),
        .product(prod_o[4]), .accumulator(acc8_o[1]), .overflow(ovf_o[4]), .load_out(lo_o[4]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    int n_assert = 0;
    int n_fail   = 0;
    int edge_n   = 0;

    localparam int HN = 2048;
    bit       h_vld [HN];
    logic [3:0] h_a [HN];
    logic [3:0] h_b [HN];
    bit       h_sm  [HN];
    bit       h_clr [HN];

    longint m_acc  [5];
    longint m_prod [5];
    bit     m_ovf  [5];
    bit     m_lo   [5];

    task automatic chk(input string tag, input int c, input longint act, input longint exp);
        n_assert++;
        assert (act === exp) else begin
            n_fail++;
            $error("FAIL %s cfg%0d edge%0d: observed %0d expected %0d", tag, c, edge_n, act, exp);
        end
    endtask

    function automatic longint dut_acc(input int c);
        case (c)
            0: return longint'(acc_o[0]);
            1: return longint'(acc_o[1]);
            2: return longint'(acc_o[2]);
            3: return longint'(acc8_o[0]);
            default: return longint'(acc8_o[1]);
        endcase
    endfunction

    // Reference: true integer product, then accumulate with range checks.
    task automatic model_op(input int c, input int e);
        longint av, bv, p, md, half, base, s;
        bit ov;
        av = longint'(h_a[e]);
        bv = longint'(h_b[e]);
        if (h_sm[e] && h_a[e][3]) av = av - 16;
        if (h_sm[e] && h_b[e][3]) bv = bv - 16;
        p = av * bv;
        m_prod[c] = p & 255;
        md   = longint'(1) << cfg_w[c];
        half = md / 2;
        ov   = 1'b0;
        if (h_sm[e]) begin
            base = h_clr[e] ? 0 : ((m_acc[c] >= half) ? m_acc[c] - md : m_acc[c]);
            s = base + p;
            if (s > half - 1) begin
                ov = 1'b1;
                if (cfg_sat[c]) s = half - 1;
            end else if (s < -half) begin
                ov = 1'b1;
                if (cfg_sat[c]) s = -half;
            end
            m_acc[c] = ((s % md) + md) % md;
        end else begin
            base = h_clr[e] ? 0 : m_acc[c];
            s = base + p;
            if (s > md - 1) begin
                ov = 1'b1;
                if (cfg_sat[c]) s = md - 1;
            end
            m_acc[c] = s % md;
        end
        m_ovf[c] = (h_clr[e] ? 1'b0 : m_ovf[c]) | ov;
    endtask

    task automatic tick(input bit ld, input logic [3:0] a, input logic [3:0] b,
                        input bit sm, input bit clr, input bit rst);
        int e;
        load         = ld;
        multiplier   = a;
        multiplicand = b;
        signed_mode  = sm;
        acc_clear    = clr;
        reset        = rst;
        @(posedge clk);
        #1;
        edge_n++;
        h_vld[edge_n] = ld && !rst;
        h_a[edge_n]   = a;
        h_b[edge_n]   = b;
        h_sm[edge_n]  = sm;
        h_clr[edge_n] = clr;
        if (rst) begin
            // Discard every token still in flight for the longest pipeline.
            for (int k = 1; k <= 4; k++) begin
                if (edge_n - k >= 0) h_vld[edge_n - k] = 1'b0;
            end
            for (int c = 0; c < 5; c++) begin
                m_acc[c] = 0; m_prod[c] = 0; m_ovf[c] = 1'b0; m_lo[c] = 1'b0;
            end
        end else begin
            for (int c = 0; c < 5; c++) begin
                e = edge_n - cfg_lat[c];
                if (e >= 1 && h_vld[e]) begin
                    model_op(c, e);
                    m_lo[c] = 1'b1;
                end else begin
                    m_lo[c] = 1'b0;
                end
            end
        end
        for (int c = 0; c < 5; c++) begin
            chk("load_out", c, longint'(lo_o[c]), longint'(m_lo[c]));
            chk("product", c, longint'(prod_o[c]), m_prod[c]);
            chk("accumulator", c, dut_acc(c), m_acc[c]);
            chk("overflow", c, longint'(ovf_o[c]), longint'(m_ovf[c]));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 4'($urandom), 4'($urandom), 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        load = 1'b0; multiplier = '0; multiplicand = '0;
        signed_mode = 1'b0; acc_clear = 1'b0; reset = 1'b1;

        // Reset state.
        tick(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
        tick(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
        chk("reset_acc", 0, longint'(acc_o[0]), 0);
        chk("reset_lo", 0, longint'(lo_o[0]), 0);

        // Unsigned 15x15 with clear: three edges after the load edge.
        tick(1'b1, 4'd15, 4'd15, 1'b0, 1'b1, 1'b0);
        idle(3);
        chk("u15x15_prod", 0, longint'(prod_o[0]), 225);
        chk("u15x15_acc", 0, longint'(acc_o[0]), 225);
        chk("u15x15_lo", 0, longint'(lo_o[0]), 1);
        idle(1);
        chk("u15x15_lo_pulse", 0, longint'(lo_o[0]), 0);

        // Signed: -8 x 7 (clear), then -8 x -8.
        tick(1'b1, 4'h8, 4'h7, 1'b1, 1'b1, 1'b0);
        tick(1'b1, 4'h8, 4'h8, 1'b1, 1'b0, 1'b0);
        idle(2);
        chk("s_m8x7_prod", 0, longint'(prod_o[0]), 200);
        idle(1);
        chk("s_m8xm8_prod", 0, longint'(prod_o[0]), 64);
        chk("s_acc", 0, longint'(acc_o[0]), 8);

        // 8-bit accumulator: saturate vs wrap, then clear-token resets overflow.
        tick(1'b1, 4'd15, 4'd15, 1'b0, 1'b1, 1'b0);
        tick(1'b1, 4'd15, 4'd15, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 4'd1, 4'd1, 1'b0, 1'b1, 1'b0);
        idle(2);
        chk("sat_acc", 3, longint'(acc8_o[0]), 255);
        chk("sat_ovf", 3, longint'(ovf_o[3]), 1);
        chk("wrap_acc", 4, longint'(acc8_o[1]), 194);
        chk("wrap_ovf", 4, longint'(ovf_o[4]), 1);
        idle(1);
        chk("clr_sat_acc", 3, longint'(acc8_o[0]), 1);
        chk("clr_sat_ovf", 3, longint'(ovf_o[3]), 0);
        chk("clr_wrap_acc", 4, longint'(acc8_o[1]), 1);

        // Reset with two tokens in flight, then load coinciding with reset.
        tick(1'b1, 4'd7, 4'd9, 1'b0, 1'b1, 1'b0);
        tick(1'b1, 4'd5, 4'd3, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
        idle(5);
        chk("midrst_acc", 0, longint'(acc_o[0]), 0);
        chk("midrst_prod", 0, longint'(prod_o[0]), 0);
        tick(1'b1, 4'd3, 4'd5, 1'b0, 1'b1, 1'b1);
        idle(4);
        chk("rst_load_lost", 0, longint'(acc_o[0]), 0);
        tick(1'b1, 4'd3, 4'd5, 1'b0, 1'b1, 1'b0);
        idle(2);
        chk("post_rst_early", 0, longint'(lo_o[0]), 0);
        idle(1);
        chk("post_rst_prod", 0, longint'(prod_o[0]), 15);

        // 20 back-to-back random loads, clear on the first.
        for (int i = 0; i < 20; i++) begin
            tick(1'b1, 4'($urandom), 4'($urandom), 1'($urandom), (i == 0), 1'b0);
        end
        idle(5);

        // Random gaps: held operands must be ignored while load is low.
        for (int i = 0; i < 40; i++) begin
            tick(1'($urandom), 4'($urandom), 4'($urandom), 1'($urandom),
                 ($urandom_range(0, 5) == 0), 1'b0);
        end

        // Exhaustive 4x4 in both modes, back to back.
        for (int sm = 0; sm < 2; sm++) begin
            for (int a = 0; a < 16; a++) begin
                for (int b = 0; b < 16; b++) begin
                    tick(1'b1, 4'(a), 4'(b), 1'(sm), ($urandom_range(0, 7) == 0), 1'b0);
                end
            end
        end
        idle(6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
